multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the RV32 datapath. Steps each instruction through

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/multicycle_control.sv | 149 ++++++++++++++
 tb/tb_multicycle_control.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the RV32 multi-cycle controller.
// Holds the state encoding, supported opcodes and error codes.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_IALU) ||
             (op == OP_LOAD)  || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory access has been waiting for mem_ready
// and flags when the wait limit is hit. TIMEOUT_CYCLES = 0 disables it.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic mem_ready,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Counter is held at zero outside an access, so every access starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!active || mem_ready) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q counts earlier wait cycles, so cnt_q == LIMIT-1 means this is the
   // LIMIT-th cycle without mem_ready; a ready in that cycle still wins.
   assign expired = (TIMEOUT_CYCLES != 0) && active && !mem_ready &&
                    (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32 datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath and memory control lines.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       EQ,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_sel,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCsrc,
   output logic       RegWrite,
   output logic       ALUsrc,
   output logic       ImmSrc,
   output logic       ALUctrl,
   output logic       WriteSrc,
   output logic       instr_retired,
   output logic       halted,
   output logic [1:0] err_code,
   output logic [2:0] dbg_state
);

   state_t     state_q, state_d;
   logic [1:0] err_q, err_d;
   logic       mem_active;
   logic       wait_expired;

   assign mem_active = (state_q == FETCH) || (state_q == MEM);

   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (mem_active),
      .mem_ready(mem_ready),
      .expired  (wait_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE:   state_d = FETCH;
         FETCH: begin
            if (mem_ready) begin
               state_d = DECODE;
            end else if (wait_expired) begin
               state_d = HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         DECODE: begin
            if (is_legal_op(op)) begin
               state_d = EXEC;
            end else begin
               state_d = HALT;
               err_d   = ERR_ILLEGAL;
            end
         end
         EXEC: begin
            if (op == OP_LOAD) begin
               state_d = MEM;
            end else if (op == OP_BRANCH) begin
               state_d = FETCH;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (mem_ready) begin
               state_d = WB;
            end else if (wait_expired) begin
               state_d = HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Moore decode; only the FETCH writes and the branch PC update look at inputs.
   always_comb begin
      mem_req       = 1'b0;
      mem_sel       = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      PCsrc         = 1'b0;
      RegWrite      = 1'b0;
      ALUsrc        = 1'b0;
      ImmSrc        = 1'b0;
      ALUctrl       = 1'b0;
      WriteSrc      = 1'b0;
      instr_retired = 1'b0;
      halted        = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         EXEC: begin
            if ((op == OP_IALU) || (op == OP_LOAD)) begin
               ALUsrc = 1'b1;
            end else if (op == OP_BRANCH) begin
               ALUctrl       = 1'b1;
               ImmSrc        = 1'b1;
               PCWrite       = !EQ;
               PCsrc         = !EQ;
               instr_retired = 1'b1;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            ALUsrc  = 1'b1;
         end
         WB: begin
            RegWrite      = 1'b1;
            WriteSrc      = (op == OP_LOAD);
            instr_retired = 1'b1;
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   assign err_code  = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cycle tables, hand-written corner
// sequences, and random instruction streams checked against a trace model.
module tb_multicycle_control;
   import cpu_ctrl_pkg::*;

   localparam int TO = 4;

   localparam logic [13:0] REQ = 14'h2000, SEL = 14'h1000, IRW = 14'h0800,
                           PCW = 14'h0400, PCS = 14'h0200, RGW = 14'h0100,
                           ASR = 14'h0080, IMS = 14'h0040, ALC = 14'h0020,
                           WRS = 14'h0010, RET = 14'h0008, HLT = 14'h0004,
                           E_ILL = 14'h0001, E_TO = 14'h0002;

   logic       clk, rst_n;
   logic [6:0] op;
   logic       EQ, mem_ready;
   logic       mem_req, mem_sel, IRWrite, PCWrite, PCsrc, RegWrite;
   logic       ALUsrc, ImmSrc, ALUctrl, WriteSrc, instr_retired, halted;
   logic [1:0] err_code;
   logic [2:0] dbg_state;
   logic [16:0] obs;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct {
      logic [6:0]  op;
      logic        eq;
      logic        mr;
      logic [16:0] exp_v;
      string       name;
   } vec_t;

   typedef struct packed {
      logic [6:0] op;
      logic       eq;
      logic       mr;
   } stim_t;

   vec_t        tbl[19];
   stim_t       stim_q[$];
   logic [16:0] exp_q[$];

   multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .EQ(EQ), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_sel(mem_sel), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .PCsrc(PCsrc), .RegWrite(RegWrite),
      .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
      .WriteSrc(WriteSrc), .instr_retired(instr_retired), .halted(halted),
      .err_code(err_code), .dbg_state(dbg_state)
   );

   assign obs = {dbg_state, mem_req, mem_sel, IRWrite, PCWrite, PCsrc,
                 RegWrite, ALUsrc, ImmSrc, ALUctrl, WriteSrc, instr_retired,
                 halted, err_code};

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no_finish required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] ev(input state_t s, input logic [13:0] o);
      return {s, o};
   endfunction

   function automatic vec_t mk(input logic [6:0] o_op, input logic eq,
                               input logic mr, input state_t s,
                               input logic [13:0] o, input string nm);
      vec_t v;
      v.op = o_op; v.eq = eq; v.mr = mr; v.exp_v = ev(s, o); v.name = nm;
      return v;
   endfunction

   function automatic bit legal(input logic [6:0] o_op);
      return o_op inside {OP_RTYPE, OP_IALU, OP_LOAD, OP_BRANCH};
   endfunction

   task automatic check(input string nm, input logic [16:0] exp_v);
      chk_cnt++;
      if (obs === exp_v) pass_cnt++;
      else $display("FAIL %s: got {state,outs}=%h required %h", nm, obs, exp_v);
   endtask

   // driver: called at posedge+1, samples at negedge, returns at posedge+1
   task automatic step(input logic [6:0] o_op, input logic eq, input logic mr,
                       input logic [16:0] exp_v, input string nm);
      op = o_op; EQ = eq; mem_ready = mr;
      @(negedge clk);
      check(nm, exp_v);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("reset_async", ev(IDLE, 14'h0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // reference trace model: one expected cycle per push
   task automatic push(input logic [6:0] o_op, input logic eq, input logic mr,
                       input state_t s, input logic [13:0] o);
      stim_t st;
      st.op = o_op; st.eq = eq; st.mr = mr;
      stim_q.push_back(st);
      exp_q.push_back(ev(s, o));
   endtask

   task automatic push_halt(input logic [13:0] err);
      repeat (3) push(7'($urandom), 1'($urandom), 1'($urandom), HALT, HLT | err);
   endtask

   task automatic access(input state_t s, input logic [13:0] base,
                         input logic [13:0] on_ready, input logic [6:0] opc,
                         output bit stop);
      int w;
      w = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
      stop = 0;
      for (int i = 0; i < w; i++) push(opc, 1'($urandom), 1'b0, s, base);
      if (w == TO) begin
         push_halt(E_TO);
         stop = 1;
      end else begin
         push(opc, 1'($urandom), 1'b1, s, base | on_ready);
      end
   endtask

   task automatic gen_instr(input logic [6:0] opc, output bit stop);
      logic eq;
      access(FETCH, REQ, IRW | PCW, 7'($urandom), stop);
      if (stop) return;
      push(opc, 1'($urandom), 1'($urandom), DECODE, 14'h0);
      if (!legal(opc)) begin
         push_halt(E_ILL);
         stop = 1;
         return;
      end
      eq = 1'($urandom);
      case (opc)
         OP_RTYPE: begin
            push(opc, eq, 1'($urandom), EXEC, 14'h0);
            push(opc, 1'($urandom), 1'($urandom), WB, RGW | RET);
         end
         OP_IALU: begin
            push(opc, eq, 1'($urandom), EXEC, ASR);
            push(opc, 1'($urandom), 1'($urandom), WB, RGW | RET);
         end
         OP_LOAD: begin
            push(opc, eq, 1'($urandom), EXEC, ASR);
            access(MEM, REQ | SEL | ASR, 14'h0, opc, stop);
            if (stop) return;
            push(opc, 1'($urandom), 1'($urandom), WB, RGW | WRS | RET);
         end
         default: push(opc, eq, 1'($urandom), EXEC,
                       IMS | ALC | RET | (eq ? 14'h0 : (PCW | PCS)));
      endcase
   endtask

   task automatic drain(input string nm);
      stim_t st;
      logic [16:0] e;
      while (exp_q.size() > 0) begin
         st = stim_q.pop_front();
         e  = exp_q.pop_front();
         step(st.op, st.eq, st.mr, e, nm);
      end
   endtask

   initial begin
      logic [6:0] legal_ops[4];
      logic [6:0] bad_ops[4];
      logic [6:0] opc;
      bit stop;

      legal_ops = '{OP_RTYPE, OP_IALU, OP_LOAD, OP_BRANCH};
      bad_ops   = '{7'b1111111, 7'b0100011, 7'b0000000, 7'b1101111};

      // add, two bne, lw with 3 wait cycles in MEM
      tbl[0]  = mk(OP_RTYPE,  0, 1, IDLE,   14'h0,             "add_idle");
      tbl[1]  = mk(OP_RTYPE,  0, 1, FETCH,  REQ | IRW | PCW,   "add_fetch");
      tbl[2]  = mk(OP_RTYPE,  0, 1, DECODE, 14'h0,             "add_decode");
      tbl[3]  = mk(OP_RTYPE,  0, 1, EXEC,   14'h0,             "add_exec");
      tbl[4]  = mk(OP_RTYPE,  0, 1, WB,     RGW | RET,         "add_wb");
      tbl[5]  = mk(OP_BRANCH, 0, 1, FETCH,  REQ | IRW | PCW,   "bne0_fetch");
      tbl[6]  = mk(OP_BRANCH, 0, 1, DECODE, 14'h0,             "bne0_decode");
      tbl[7]  = mk(OP_BRANCH, 0, 1, EXEC,   IMS | ALC | PCW | PCS | RET, "bne0_exec");
      tbl[8]  = mk(OP_BRANCH, 1, 1, FETCH,  REQ | IRW | PCW,   "bne1_fetch");
      tbl[9]  = mk(OP_BRANCH, 1, 1, DECODE, 14'h0,             "bne1_decode");
      tbl[10] = mk(OP_BRANCH, 1, 1, EXEC,   IMS | ALC | RET,   "bne1_exec");
      tbl[11] = mk(OP_LOAD,   0, 1, FETCH,  REQ | IRW | PCW,   "lw_fetch");
      tbl[12] = mk(OP_LOAD,   0, 1, DECODE, 14'h0,             "lw_decode");
      tbl[13] = mk(OP_LOAD,   0, 1, EXEC,   ASR,               "lw_exec");
      tbl[14] = mk(OP_LOAD,   0, 0, MEM,    REQ | SEL | ASR,   "lw_mem_w1");
      tbl[15] = mk(OP_LOAD,   1, 0, MEM,    REQ | SEL | ASR,   "lw_mem_w2");
      tbl[16] = mk(OP_LOAD,   0, 0, MEM,    REQ | SEL | ASR,   "lw_mem_w3");
      tbl[17] = mk(OP_LOAD,   0, 1, MEM,    REQ | SEL | ASR,   "lw_mem_rdy");
      tbl[18] = mk(OP_LOAD,   0, 1, WB,     RGW | WRS | RET,   "lw_wb");

      rst_n = 1'b1; op = '0; EQ = 1'b0; mem_ready = 1'b0;
      #1;
      do_reset();
      for (int i = 0; i < 19; i++) step(tbl[i].op, tbl[i].eq, tbl[i].mr, tbl[i].exp_v, tbl[i].name);

      // illegal opcode: halt is sticky, mem_ready ignored
      do_reset();
      step(7'h7f, 0, 1, ev(IDLE, 14'h0), "ill_idle");
      step(7'h7f, 0, 1, ev(FETCH, REQ | IRW | PCW), "ill_fetch");
      step(7'h7f, 0, 1, ev(DECODE, 14'h0), "ill_decode");
      for (int i = 0; i < 4; i++) step(7'h7f, 0, 1'(i), ev(HALT, HLT | E_ILL), "ill_halt");

      // fetch timeout after TO wait cycles
      do_reset();
      step(OP_RTYPE, 0, 0, ev(IDLE, 14'h0), "to_idle");
      for (int i = 0; i < TO; i++) step(OP_RTYPE, 0, 0, ev(FETCH, REQ), "to_wait");
      step(OP_RTYPE, 0, 1, ev(HALT, HLT | E_TO), "to_halt");
      step(OP_RTYPE, 0, 0, ev(HALT, HLT | E_TO), "to_halt_hold");

      // ready on the last allowed cycle completes the fetch
      do_reset();
      step(OP_RTYPE, 0, 0, ev(IDLE, 14'h0), "edge_idle");
      for (int i = 0; i < TO - 1; i++) step(OP_RTYPE, 0, 0, ev(FETCH, REQ), "edge_wait");
      step(OP_RTYPE, 0, 1, ev(FETCH, REQ | IRW | PCW), "edge_ready");
      step(OP_RTYPE, 0, 0, ev(DECODE, 14'h0), "edge_decode");
      step(OP_RTYPE, 0, 0, ev(EXEC, 14'h0), "edge_exec");
      step(OP_RTYPE, 0, 0, ev(WB, RGW | RET), "edge_wb");

      // reset during MEM of a lw
      do_reset();
      step(OP_LOAD, 0, 1, ev(IDLE, 14'h0), "abort_idle");
      step(OP_LOAD, 0, 1, ev(FETCH, REQ | IRW | PCW), "abort_fetch");
      step(OP_LOAD, 0, 1, ev(DECODE, 14'h0), "abort_decode");
      step(OP_LOAD, 0, 1, ev(EXEC, ASR), "abort_exec");
      step(OP_LOAD, 0, 0, ev(MEM, REQ | SEL | ASR), "abort_mem");
      mem_ready = 1'b1;
      do_reset();
      step(OP_LOAD, 0, 1, ev(IDLE, 14'h0), "abort_post_idle");
      step(OP_LOAD, 0, 0, ev(FETCH, REQ), "abort_post_fetch");

      // random instruction streams against the trace model
      for (int s = 0; s < 25; s++) begin
         do_reset();
         push(7'($urandom), 1'($urandom), 1'($urandom), IDLE, 14'h0);
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 15) == 0) opc = bad_ops[$urandom_range(0, 3)];
            else                            opc = legal_ops[$urandom_range(0, 3)];
            gen_instr(opc, stop);
            if (stop) break;
         end
         drain("random");
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
